// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 Hz: scan counters, syncs, blank,
// line/frame strobes and a free-running frame counter, all registered.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       h_wrap;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       blank_nxt;
    logic       ls_nxt;
    logic       fs_nxt;
    logic [7:0] fc_nxt;

    // Flags are decoded from the next position so they line up with it.
    always_comb begin
        h_wrap    = (DrawX == H_LAST);
        x_nxt     = h_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt     = DrawY;
        if (h_wrap) begin
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
        hs_nxt    = !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
        vs_nxt    = !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
        blank_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        ls_nxt    = (x_nxt == 10'd0);
        fs_nxt    = ls_nxt && (y_nxt == 10'd0);
        fc_nxt    = fs_nxt ? frame_count + 8'd1 : frame_count;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            hs          <= hs_nxt;
            vs          <= vs_nxt;
            blank       <= blank_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            frame_count <= fc_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken-raster instances checked
// every cycle against a position-from-elapsed-time reference model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic [9:0] ax, ay, bx, by;
    logic       ahs, avs, abl, als, afs;
    logic       bhs, bvs, bbl, bls, bfs;
    logic [7:0] afc, bfc;

    vga_timing_gen dut_a (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(ax), .DrawY(ay), .hs(ahs), .vs(avs), .blank(abl),
        .line_start(als), .frame_start(afs), .frame_count(afc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(bx), .DrawY(by), .hs(bhs), .vs(bvs), .blank(bbl),
        .line_start(bls), .frame_start(bfs), .frame_count(bfc)
    );

    // Raster state follows directly from cycles elapsed since release.
    function automatic exp_t ref_model(int t, int ha, int hf, int hsw,
                                       int hb, int va, int vf, int vsw,
                                       int vb);
        exp_t e;
        int ht, vt, x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (t < 0) begin
            e.x = 10'(ht - 1); e.y = 10'(vt - 1);
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'd0;
        end else begin
            x = t % ht;
            y = (t / ht) % vt;
            e.x = 10'(x); e.y = 10'(y);
            e.hs = !(x >= ha + hf && x < ha + hf + hsw);
            e.vs = !(y >= va + vf && y < va + vf + vsw);
            e.blank = (x < ha) && (y < va);
            e.ls = (x == 0);
            e.fs = (x == 0) && (y == 0);
            e.fc = 8'(((t / (ht * vt)) + 1) % 256);
        end
        return e;
    endfunction

    pair_t q[$];
    int    t = -1;
    int    vectors = 0;
    int    miscompares = 0;
    bit    done = 0;

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) t = -1;
        else          t = t + 1;
        q.push_back('{ref_model(t, 640, 16, 96, 48, 480, 10, 2, 33),
                      ref_model(t, 8, 2, 3, 2, 4, 1, 2, 1)});
    end

    task automatic check(string name, exp_t act, exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d actual x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d",
                     name, t, act.x, act.y, act.hs, act.vs, act.blank,
                     act.ls, act.fs, act.fc, exp.x, exp.y, exp.hs, exp.vs,
                     exp.blank, exp.ls, exp.fs, exp.fc);
        end
    endtask

    // Only the newest expectation is observable by the time we sample.
    always @(negedge vga_clk) begin
        pair_t p;
        if (!done) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL queue_empty t=%0d actual none required entry", t);
            end else begin
                p = q[$];
                q.delete();
                check("full", {ax, ay, ahs, avs, abl, als, afs, afc}, p.a);
                check("small", {bx, by, bhs, bvs, bbl, bls, bfs, bfc}, p.b);
            end
        end
    end

    initial begin
        repeat (3) @(posedge vga_clk);
        #3 reset_n = 1'b1;
        repeat (260 * 120 + $urandom_range(0, 50)) @(posedge vga_clk);
        for (int k = 0; k < 6; k++) begin
            #($urandom_range(1, 4)) reset_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge vga_clk);
            #3 reset_n = 1'b1;
            repeat ($urandom_range(20, 400)) @(posedge vga_clk);
        end
        repeat (300) @(posedge vga_clk);
        #2 done = 1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. It runs on the 25 MHz pixel clock and produces the scan coordinates (DrawX, DrawY), the active-video flag (blank) and the sync pulses. The sprite/background stages directly downstream consume these signals to address their ROMs and to gate their colour outputs. It also emits per-frame and per-line strobes plus a free-running frame counter, which the animation logic uses to step sprite frames.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- vga_clk  in  1  pixel clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  high during active video (DrawX < H_ACTIVE and DrawY < V_ACTIVE); downstream stages drive colour only when it is high
- line_start  out  1  one-cycle pulse when DrawX == 0
- frame_start  out  1  one-cycle pulse when DrawX == 0 and DrawY == 0
- frame_count  out  8  frames started since reset, wraps modulo 256

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both fit in 10 bits.
- The horizontal counter (DrawX) increments every cycle. At H_TOTAL-1 it wraps to 0.
- The vertical counter (DrawY) increments only on a horizontal wrap. At V_TOTAL-1, together with a horizontal wrap, it wraps to 0.
- hs = 0 exactly when H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751 by default); otherwise hs = 1.
- vs = 0 exactly when V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491 by default); otherwise vs = 1.
- vs is a function of DrawY alone, so it changes at DrawX == 0.
- All outputs are registered and mutually consistent. hs, vs, blank, line_start and frame_start are computed from the next-state counter values, so in any cycle they describe the (DrawX, DrawY) presented in that same cycle. There are no combinational paths from inputs to outputs.
- frame_count increments on the same edge that asserts frame_start. It wraps from 255 to 0.
- Reset (asynchronous, applied while reset_n = 0):
  - DrawX = H_TOTAL-1, DrawY = V_TOTAL-1, i.e. the last position of a frame.
  - hs = 1, vs = 1, blank = 0, line_start = 0, frame_start = 0, frame_count = 0.
- The first rising edge after reset_n deasserts moves the position to (0,0), asserts blank, line_start and frame_start, and sets frame_count = 1.
- Reset asserted mid-frame immediately forces the reset values on all outputs, with no wait for a clock edge. No partial line or frame state survives reset.

## Timing
- Latency: 0 cycles between a counter value and its derived flags, since both are driven from the same edge.
- Line period: exactly H_TOTAL cycles.
  - blank is high for H_ACTIVE consecutive cycles per visible line.
  - hs is low for H_SYNC consecutive cycles per line.
- Frame period: exactly H_TOTAL*V_TOTAL cycles (420000).
  - vs is low for V_SYNC*H_TOTAL consecutive cycles (1600).
  - blank is high for H_ACTIVE*V_ACTIVE cycles per frame (307200).
- line_start is high 1 of every H_TOTAL cycles. frame_start is high 1 of every H_TOTAL*V_TOTAL cycles.
- Simultaneous wraps: at (H_TOTAL-1, V_TOTAL-1) the next edge wraps both counters in the same cycle. Both line_start and frame_start assert on that edge.
- Downstream ROMs read on the falling edge of vga_clk. DrawX and DrawY must therefore be stable for the full cycle after the rising edge. Do not insert glitch-prone decode between the counter registers and these outputs.

## Test plan
- Reset then release: with reset_n low, DrawX=799, DrawY=524, hs=vs=1, blank=0, frame_count=0. On the first edge after release: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=1.
- Horizontal line timing: over one line, blank is high for DrawX 0..639, hs is low for DrawX 656..751 (96 cycles), and DrawX goes 799 -> 0 with DrawY incrementing by 1.
- Vertical timing over a full frame: vs is low for DrawY 490..491 (1600 cycles), blank counts 307200 cycles, and frame_start recurs exactly every 420000 cycles.
- Double wrap: at (799,524) the next edge gives (0,0) with line_start and frame_start both high for exactly one cycle.
- frame_count wrap: after 256 frame_start pulses following reset, frame_count reads 0 and then increments to 1 on the next frame.
- Mid-frame reset: drop reset_n asynchronously at (300,200). Outputs take reset values before the next clock edge, and after release the sequence restarts at (0,0) with frame_count=1.
